// File: rtl/addsub_pkg.sv
// Shared types and constants for the byte-serial adder/subtractor.
package addsub_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_addsub.sv
// One 8-bit add/subtract slice; c7 (carry into the MSB) only with ADDSUB_SEQ_OVF_EN.
import addsub_pkg::*;

module byte_addsub (
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
`ifdef ADDSUB_SEQ_OVF_EN
  ,
  output logic              c7
`endif
);

  logic [BYTE_W-1:0] w_bx;
  logic [BYTE_W-1:0] w_lo;
  logic [1:0]        w_hi;

  assign w_bx = b ^ {BYTE_W{sub}};
  // Split at bit 7 so the carry into the MSB is visible.
  assign w_lo = {1'b0, a[BYTE_W-2:0]} + {1'b0, w_bx[BYTE_W-2:0]}
              + {{(BYTE_W-1){1'b0}}, cin};
  assign w_hi = {1'b0, a[BYTE_W-1]} + {1'b0, w_bx[BYTE_W-1]}
              + {1'b0, w_lo[BYTE_W-1]};
  assign sum  = {w_hi[0], w_lo[BYTE_W-2:0]};
  assign cout = w_hi[1];

`ifdef ADDSUB_SEQ_OVF_EN
  assign c7 = w_lo[BYTE_W-1];
`endif

endmodule

// File: rtl/addsub_seq.sv
// Byte-serial adder/subtractor, one byte per cycle through a shared slice.
// Define ADDSUB_SEQ_OVF_EN to add the registered signed-overflow output ovf.
import addsub_pkg::*;

module addsub_seq #(
  parameter int NBYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*NBYTES-1:0]     op_a,
  input  logic [8*NBYTES-1:0]     op_b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*NBYTES-1:0]     result,
  output logic                    cout
`ifdef ADDSUB_SEQ_OVF_EN
  ,
  output logic                    ovf
`endif
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t            r_state;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_sub;
  logic [IW-1:0]     r_idx;
  logic              r_carry;
  logic [W-1:0]      r_result;
  logic              r_cout;

  logic [BYTE_W-1:0] w_a;
  logic [BYTE_W-1:0] w_b;
  logic [BYTE_W-1:0] w_sum;
  logic              w_cout;
  logic              w_last;

  assign w_a    = r_a[r_idx*BYTE_W +: BYTE_W];
  assign w_b    = r_b[r_idx*BYTE_W +: BYTE_W];
  assign w_last = (r_idx == IW'(NBYTES - 1));

`ifdef ADDSUB_SEQ_OVF_EN
  logic w_c7;
  logic r_ovf;
  assign ovf = r_ovf;
`endif

  byte_addsub u_slice (
    .a    (w_a),
    .b    (w_b),
    .cin  (r_carry),
    .sub  (r_sub),
    .sum  (w_sum),
    .cout (w_cout)
`ifdef ADDSUB_SEQ_OVF_EN
    ,
    .c7   (w_c7)
`endif
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign cout      = r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_sub   <= sub;
            r_idx   <= '0;
            r_carry <= sub;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_result[r_idx*BYTE_W +: BYTE_W] <= w_sum;
          r_carry <= w_cout;
          if (w_last) begin
            r_cout  <= w_cout;
`ifdef ADDSUB_SEQ_OVF_EN
            r_ovf   <= w_c7 ^ w_cout;
`endif
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Randomized and directed checks of addsub_seq against an arithmetic model.
module tb_addsub_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
`ifdef ADDSUB_SEQ_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  addsub_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout)
`ifdef ADDSUB_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, output logic [W-1:0] r,
                       output logic c, output logic o);
    logic [W:0] t;
    if (s) begin
      t = {1'b0, a} - {1'b0, b};
      c = (a >= b);
      o = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
    end else begin
      t = {1'b0, a} + {1'b0, b};
      c = t[W];
      o = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    end
    r = t[W-1:0];
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input int stall);
    logic [W-1:0] er;
    logic         ec;
    logic         eo;
    int           n;
    model(a, b, s, er, ec, eo);
    @(negedge clk);
    chk("in_ready", in_ready, 1);
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    sub       = s;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    sub      = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, NB);
    chk("result", result, er);
    chk("cout", cout, ec);
`ifdef ADDSUB_SEQ_OVF_EN
    chk("ovf", ovf, eo);
`endif
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      op_a     = $urandom;
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_result", result, er);
      chk("stall_cout", cout, ec);
      chk("stall_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("exit_valid", out_valid, 0);
    chk("exit_ready", in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", in_ready, 1);

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 0);
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 5);

    // Abort mid-RUN while byte 2 is being computed.
    @(negedge clk);
    in_valid = 1'b1;
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h0BAD_F00D;
    sub      = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_result", result, 0);
    chk("abort_cout", cout, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready2", in_ready, 1);
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      run_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
